// File: rtl/prog_encoder_pkg.sv
// rtl/prog_encoder_pkg.sv - opcodes, ALU codes and control-bundle definitions shared by encoder and decoder
package prog_encoder_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_SINN = 4'h3;
    localparam logic [3:0] OP_MAC  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hE;
    localparam logic [3:0] OP_ST   = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_MUL  = 3'b001;
    localparam logic [2:0] ALU_SINN = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu1;
        logic [2:0] alu2;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam ctrl_t C_NOP  = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, mem_read: 1'b0,
                                 alu_src: 1'b0, reg_dst: 1'b0, alu1: ALU_NONE, alu2: ALU_NONE};
    localparam ctrl_t C_ADD  = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0, mem_read: 1'b0,
                                 alu_src: 1'b0, reg_dst: 1'b1, alu1: ALU_ADD, alu2: ALU_NONE};
    localparam ctrl_t C_ADDI = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0, mem_read: 1'b0,
                                 alu_src: 1'b1, reg_dst: 1'b0, alu1: ALU_ADD, alu2: ALU_NONE};
    localparam ctrl_t C_MUL  = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0, mem_read: 1'b0,
                                 alu_src: 1'b0, reg_dst: 1'b1, alu1: ALU_MUL, alu2: ALU_NONE};
    localparam ctrl_t C_SINN = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0, mem_read: 1'b0,
                                 alu_src: 1'b0, reg_dst: 1'b1, alu1: ALU_SINN, alu2: ALU_NONE};
    localparam ctrl_t C_MAC  = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0, mem_read: 1'b0,
                                 alu_src: 1'b0, reg_dst: 1'b1, alu1: ALU_MUL, alu2: ALU_ADD};
    localparam ctrl_t C_LD   = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_write: 1'b0, mem_read: 1'b1,
                                 alu_src: 1'b1, reg_dst: 1'b0, alu1: ALU_ADD, alu2: ALU_NONE};
    localparam ctrl_t C_ST   = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b1, mem_read: 1'b0,
                                 alu_src: 1'b1, reg_dst: 1'b0, alu1: ALU_ADD, alu2: ALU_NONE};

    // MemtoReg is meaningless without RegWrite; a store has no destination so RegDst is free too
    localparam ctrl_t CARE_ALL    = '1;
    localparam ctrl_t CARE_NO_MTR = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_write: 1'b1, mem_read: 1'b1,
                                      alu_src: 1'b1, reg_dst: 1'b1, alu1: 3'b111, alu2: 3'b111};
    localparam ctrl_t CARE_ST     = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_write: 1'b1, mem_read: 1'b1,
                                      alu_src: 1'b1, reg_dst: 1'b0, alu1: 3'b111, alu2: 3'b111};

    function automatic logic ctrl_match(input ctrl_t a, input ctrl_t b, input ctrl_t care);
        logic [CTRL_W-1:0] diff;
        diff = (a ^ b) & care;
        return diff == '0;
    endfunction

endpackage

// File: rtl/prog_encoder_if.sv
// rtl/prog_encoder_if.sv - control-bundle handshake interface into the program encoder
interface prog_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_halt;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegDst;
    logic       MemRead;
    logic [2:0] ALUControl1;
    logic [2:0] ALUControl2;
    logic [3:0] in_rs;
    logic [3:0] in_rt;
    logic [3:0] in_rd;
    logic [3:0] in_imm;

    modport master (
        output in_valid, in_halt, RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, MemRead,
               ALUControl1, ALUControl2, in_rs, in_rt, in_rd, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_halt, RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, MemRead,
               ALUControl1, ALUControl2, in_rs, in_rt, in_rd, in_imm,
        output in_ready
    );
endinterface

// File: rtl/prog_encoder_map.sv
// rtl/prog_encoder_map.sv - combinational control-bundle to instruction-word mapping with legality flag
module prog_encoder_map
    import prog_encoder_pkg::*;
(
    input  ctrl_t       ctrl,
    input  logic        halt,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [3:0]  rd,
    input  logic [3:0]  imm,
    output logic [15:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        if (halt) begin
            word  = {OP_HALT, 12'h000};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_NOP, CARE_NO_MTR)) begin
            word  = {OP_NOP, 12'h000};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_ADD, CARE_ALL)) begin
            word  = {OP_ADD, rs, rt, rd};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_ADDI, CARE_ALL)) begin
            word  = {OP_ADDI, rs, rt, imm};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_MUL, CARE_ALL)) begin
            word  = {OP_MUL, rs, rt, rd};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_SINN, CARE_ALL)) begin
            word  = {OP_SINN, rs, rt, rd};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_MAC, CARE_ALL)) begin
            word  = {OP_MAC, rs, rt, rd};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_LD, CARE_ALL)) begin
            word  = {OP_LD, rs, rt, imm};
            legal = 1'b1;
        end else if (ctrl_match(ctrl, C_ST, CARE_ST)) begin
            word  = {OP_ST, rs, rt, imm};
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/prog_encoder.sv
// rtl/prog_encoder.sv - program loader: encodes control bundles into imem writes; PROG_ENCODER_CHECK_EN drops illegal bundles and pulses err
module prog_encoder
    import prog_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IW     = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_encoder_if.slave     bus,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [IW-1:0]     imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    generate
        if (IW != 16) begin : g_iw_check
            $error("prog_encoder: IW must be 16");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST   = '1;
    localparam logic [ADDR_W-1:0] PENULT = LAST - 1'b1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    ctrl_t             ctrl;
    logic [15:0]       word;
    logic [15:0]       wdata_sel;
    logic              legal;
    logic              accept;
    logic              advance;
    logic              do_write;
    logic              err_set;

    assign ctrl = '{reg_write: bus.RegWrite, mem_to_reg: bus.MemtoReg, mem_write: bus.MemWrite,
                    mem_read: bus.MemRead, alu_src: bus.ALUSrc, reg_dst: bus.RegDst,
                    alu1: bus.ALUControl1, alu2: bus.ALUControl2};

    prog_encoder_map u_map (
        .ctrl  (ctrl),
        .halt  (bus.in_halt),
        .rs    (bus.in_rs),
        .rt    (bus.in_rt),
        .rd    (bus.in_rd),
        .imm   (bus.in_imm),
        .word  (word),
        .legal (legal)
    );

    // the last address is reserved for the HALT written by FLUSH
    assign bus.in_ready = (state == ST_LOAD) && (cnt != LAST);
    assign accept       = bus.in_valid & bus.in_ready;
    assign busy         = (state == ST_LOAD) || (state == ST_FLUSH);

`ifdef PROG_ENCODER_CHECK_EN
    assign do_write  = accept & legal;
    assign advance   = accept & legal & ~bus.in_halt;
    assign err_set   = accept & ~legal;
    assign wdata_sel = word;
`else
    assign do_write  = accept;
    assign advance   = accept & ~bus.in_halt;
    assign err_set   = 1'b0;
    assign wdata_sel = legal ? word : {OP_NOP, 12'h000};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            err     <= err_set;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                        done  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (do_write) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= cnt;
                        imem_wdata <= wdata_sel;
                    end
                    if (accept && bus.in_halt) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (advance) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == PENULT) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= LAST;
                    imem_wdata <= {OP_HALT, 12'h000};
                    state      <= ST_DONE;
                    done       <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_encoder.sv
// tb/tb_prog_encoder.sv - scoreboard bench for prog_encoder with a 3-bit address space
module tb_prog_encoder;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    prog_encoder_if bus_if ();

    prog_encoder #(.ADDR_W(AW), .IW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   wr_count = 0;
    int   err_seen = 0;
    int   wr_cycle [8];

    // control vector order: {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALU1, ALU2}
    localparam logic [11:0] K_NOP     = {6'b000000, 3'b111, 3'b111};
    localparam logic [11:0] K_NOP_MTR = {6'b010000, 3'b111, 3'b111};
    localparam logic [11:0] K_ADD     = {6'b110001, 3'b000, 3'b111};
    localparam logic [11:0] K_ADDI    = {6'b110010, 3'b000, 3'b111};
    localparam logic [11:0] K_MUL     = {6'b110001, 3'b001, 3'b111};
    localparam logic [11:0] K_SINN    = {6'b110001, 3'b010, 3'b111};
    localparam logic [11:0] K_MAC     = {6'b110001, 3'b001, 3'b000};
    localparam logic [11:0] K_LD      = {6'b100110, 3'b000, 3'b111};
    localparam logic [11:0] K_ST      = {6'b001010, 3'b000, 3'b111};
    localparam logic [11:0] K_BAD     = {6'b111001, 3'b000, 3'b111};

    logic [15:0] mac_words [7] = '{16'h4012, 16'h4123, 16'h4234, 16'h4345, 16'h4456, 16'h4567, 16'h4678};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (err === 1'b1) err_seen++;
        if (imem_we === 1'b1) begin
            wr_count++;
            wr_cycle[imem_addr] = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%h@%0d required=none", imem_wdata, imem_addr);
            end else begin
                e = sb.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL imem_write actual=%h@%0d required=%h@%0d",
                             imem_wdata, imem_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic drive(input logic [11:0] k, input logic halt,
                         input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic [3:0] imm);
        {bus_if.RegWrite, bus_if.MemtoReg, bus_if.MemWrite,
         bus_if.MemRead, bus_if.ALUSrc, bus_if.RegDst} = k[11:6];
        bus_if.ALUControl1 = k[5:3];
        bus_if.ALUControl2 = k[2:0];
        bus_if.in_halt     = halt;
        bus_if.in_rs       = rs;
        bus_if.in_rt       = rt;
        bus_if.in_rd       = rd;
        bus_if.in_imm      = imm;
    endtask

    // returns #1 after the transfer edge so registered outputs can be sampled directly
    task automatic send(input logic [11:0] k, input logic halt,
                        input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic [3:0] imm);
        int n;
        @(negedge clk);
        drive(k, halt, rs, rt, rd, imm);
        bus_if.in_valid = 1'b1;
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_ready_timeout", {31'd0, bus_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
        sb.push_back(exp_t'({a, d}));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int w0;
        logic [AW-1:0] a;
        reset = 1'b1;
        start = 1'b0;
        bus_if.in_valid = 1'b0;
        drive(K_NOP, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        check("rst_outputs", {imem_we, busy, done, err, bus_if.in_ready}, 0);
        check("rst_addr_data", {imem_addr, imem_wdata}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_ready", {31'd0, bus_if.in_ready}, 0);

        pulse_start();
        check("load_busy_ready", {busy, bus_if.in_ready, done}, 32'b110);

        push(3'd0, 16'hE465);
        send(K_LD, 1'b0, 4'h4, 4'h6, 4'h0, 4'h5);
        push(3'd1, 16'hF472);
        send(K_ST, 1'b0, 4'h4, 4'h7, 4'h0, 4'h2);
        push(3'd2, 16'hB000);
        send(K_BAD, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
        check("halt_status", {done, busy, bus_if.in_ready}, 32'b100);
        check("halt_write", {imem_we, imem_wdata}, {15'd0, 1'b1, 16'hB000});
        drain("drain_ld_st_halt");
        check("ld_st_back_to_back", wr_cycle[1] - wr_cycle[0], 1);

        w0 = wr_count;
        @(negedge clk);
        drive(K_ADD, 1'b0, 4'h1, 4'h2, 4'h3, 4'h0);
        bus_if.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("done_ignores_valid", wr_count - w0, 0);
        check("done_held", {31'd0, done}, 1);

        pulse_start();
        check("restart_clears_done", {done, busy}, 32'b01);
        push(3'd0, 16'h1123);
        send(K_ADD, 1'b0, 4'h1, 4'h2, 4'h3, 4'h0);
        check("add_latency", {imem_we, imem_addr, imem_wdata}, {12'd0, 1'b1, 3'd0, 16'h1123});
        push(3'd1, 16'h9569);
        send(K_ADDI, 1'b0, 4'h5, 4'h6, 4'h0, 4'h9);
        push(3'd2, 16'h2789);
        send(K_MUL, 1'b0, 4'h7, 4'h8, 4'h9, 4'h0);
        push(3'd3, 16'h3ABC);
        send(K_SINN, 1'b0, 4'hA, 4'hB, 4'hC, 4'h0);
        drain("drain_r_types");

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_status", {imem_we, busy, done, err, bus_if.in_ready}, 0);
        check("async_rst_addr_data", {imem_addr, imem_wdata}, 0);
        @(negedge clk);
        reset = 1'b0;
        w0 = wr_count;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {wr_count - w0, 31'd0, busy}, 0);

        pulse_start();
        for (int i = 0; i < 7; i++) begin
            push(AW'(i), mac_words[i]);
            send(K_MAC, 1'b0, 4'(i), 4'(i + 1), 4'(i + 2), 4'h0);
            if (i == 2) begin
                pulse_start();
                check("start_ignored_in_load", {31'd0, busy}, 1);
            end
        end
        check("flush_status", {busy, bus_if.in_ready, done}, 32'b100);
        push(3'd7, 16'hB000);
        @(posedge clk);
        #1;
        check("flush_write", {imem_we, imem_addr, imem_wdata}, {12'd0, 1'b1, 3'd7, 16'hB000});
        check("flush_done", {done, busy}, 32'b10);
        drain("drain_mac_fill");

        pulse_start();
`ifdef PROG_ENCODER_CHECK_EN
        send(K_BAD, 1'b0, 4'h1, 4'h2, 4'h3, 4'h0);
        check("illegal_err_pulse", {imem_we, err}, 32'b01);
        a = 3'd0;
`else
        push(3'd0, 16'h0000);
        send(K_BAD, 1'b0, 4'h1, 4'h2, 4'h3, 4'h0);
        check("illegal_as_nop", {imem_we, err, imem_wdata}, {14'd0, 2'b10, 16'h0000});
        a = 3'd1;
`endif
        @(posedge clk);
        #1;
        check("err_one_cycle", {31'd0, err}, 0);
        push(a, 16'h0000);
        send(K_NOP_MTR, 1'b0, 4'h5, 4'h5, 4'h5, 4'h5);
        push(a + 3'd1, 16'hB000);
        send(K_NOP, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        drain("drain_illegal_nop_halt");
`ifdef PROG_ENCODER_CHECK_EN
        check("err_pulse_count", err_seen, 1);
`else
        check("err_pulse_count", err_seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_encoder.md
PROG_ENCODER -- requirements
Module: prog_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width; depth = 2**ADDR_W.
REQ-002 Parameter IW, default 16: instruction word width (fixed 16; any other value is illegal).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins a new program load at address 0.
REQ-006 in_valid / in_ready  input / output  1 / 1  bundle handshake; transfer when both high at a clock edge.
REQ-007 in_halt  input  1  bundle is HALT; all control fields are ignored.
REQ-008 RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, MemRead  input  1 each  control bundle bits, same meaning as the decode side.
REQ-009 ALUControl1, ALUControl2  input  3 each  ALU operation codes.
REQ-010 in_rs, in_rt, in_rd, in_imm  input  4 each  operand fields.
REQ-011 imem_we, imem_addr, imem_wdata  output  1 / ADDR_W / 16  registered instruction-memory write port.
REQ-012 busy, done, err  output  1 each  loading, HALT written, single-cycle illegal-bundle pulse.

Function
REQ-013 Encoding SHALL match exact bundles (MemtoReg is don't-care when RegWrite=0): NOP 0000 (all enables 0, ALU1=ALU2=111, ALUSrc=0, RegDst=0); ADD 0001 (RW=1, MtR=1, ALU1=000, ALU2=111, ALUSrc=0, RegDst=1); ADDI 1001 (as ADD with ALUSrc=1, RegDst=0); MUL 0010 (ALU1=001, ALU2=111, R-type); SINN 0011 (ALU1=010, ALU2=111, R-type); MAC 0100 (ALU1=001, ALU2=000, R-type); LD 1110 (RW=1, MtR=0, MR=1, ALU1=000, ALU2=111, ALUSrc=1, RegDst=0); ST 1111 (RW=0, MW=1, MR=0, ALU1=000, ALU2=111, ALUSrc=1); HALT 1011 (in_halt=1).
REQ-014 Word format: R-type {op,rs,rt,rd}; I-type (ADDI/LD/ST) {op,rs,rt,imm}; NOP/HALT {op,12'h000}.
REQ-015 FSM states IDLE, LOAD, FLUSH, DONE; start in IDLE or DONE -> LOAD with address counter = 0; start in LOAD/FLUSH ignored.
REQ-016 in_ready = 1 only in LOAD with address counter < 2**ADDR_W-1.
REQ-017 Accepted legal bundle: imem_we=1 next cycle with current address and encoded word; counter increments (latency 1 cycle, throughput 1/cycle).
REQ-018 Accepted HALT: writes 16'hB000, LOAD -> DONE; done=1 from the cycle of that write until next start.
REQ-019 Counter reaching 2**ADDR_W-1 in LOAD: LOAD -> FLUSH; FLUSH writes 16'hB000 at last address next cycle, then -> DONE; no bundle accepted in FLUSH.
REQ-020 busy = 1 in LOAD and FLUSH; imem_we is 0 in all cycles not listed above.

Reset
REQ-021 reset SHALL force IDLE, counter 0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, in_ready=0, mid-load included; no partial write is issued after reset deasserts.

Configuration
REQ-022 Macro PROG_ENCODER_CHECK_EN defined: illegal bundle is accepted, not written, counter unchanged, err pulses 1 cycle.
REQ-023 Macro undefined: illegal bundle is written as 16'h0000 (NOP) and counter increments; err tied 0.

Structure
REQ-024 Opcode constants (OP_NOP..OP_HALT) and ALU code constants SHALL live in a shared package used also by the decoder.
REQ-025 Combinational bundle-to-word logic SHALL be sub-module prog_encoder_map (outputs word, legal); prog_encoder holds FSM, counter and output registers.

Verification
REQ-026 start, ADD rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr 0, wdata 16'h1123.
REQ-027 LD rs=4 rt=6 imm=5 then ST rs=4 rt=7 imm=2 back-to-back -> 16'hE465 @0, 16'hF472 @1 on consecutive cycles.
REQ-028 HALT bundle at addr 2 -> 16'hB000 @2, done=1, busy=0, in_ready=0; further in_valid ignored.
REQ-029 ADDR_W=3, seven MAC bundles -> addresses 0..6 written, in_ready drops, 16'hB000 @7, done=1.
REQ-030 Illegal bundle (MemWrite=1, RegWrite=1): with CHECK_EN err pulse and no write; without, 16'h0000 written.
REQ-031 reset asserted during LOAD at addr 4 -> all outputs 0 asynchronously, IDLE; new start writes from addr 0.
